br_resolver: RTL and testbench

Branch resolution unit in the execute stage; the return path that closes the loop with the fetch-stage branch predictor. Fetch enqueues one prediction record per predicted control-flow instruction (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL). When execute resolves that instruction, the unit compares the actual outcome against the oldest record. It then produces the predictor update pulse (`br_sig_o`, `miss_pred_o`) and, on a misprediction, a PC redirect followed by a fixed squash window.

---
 rtl/br_resolver.sv | 140 ++++++++++++++
 tb/tb_br_resolver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/br_resolver.sv
// Branch resolution unit: checks execute-stage outcomes against the
// fetch-stage prediction queue, pulses predictor updates, and on a
// mispredict redirects fetch and holds for a fixed squash window.
module br_resolver #(
   parameter int DEPTH     = 4,
   parameter int FLUSH_CYC = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic [31:0]              push_pc_i,
   input  logic                     push_taken_i,
   input  logic [31:0]              push_target_i,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o,
   input  logic                     resolve_i,
   input  logic [31:0]              res_pc_i,
   input  logic                     res_taken_i,
   input  logic [31:0]              res_target_i,
   output logic                     br_sig_o,
   output logic                     miss_pred_o,
   output logic                     redirect_o,
   output logic [31:0]              redirect_pc_o,
   output logic                     err_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [3:0]  HOLD_INIT = 4'(FLUSH_CYC);

   typedef enum logic {RUN, HOLD} state_t;

   state_t          state;
   logic [3:0]      hold_cnt;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [PW:0]     cnt;

   logic [31:0]     pc_mem     [DEPTH];
   logic            taken_mem  [DEPTH];
   logic [31:0]     target_mem [DEPTH];

   logic [31:0]     hd_pc;
   logic            hd_taken;
   logic [31:0]     hd_target;
   logic            empty;
   logic            full;
   logic            pc_bad;
   logic            miss;
   logic            do_res;
   logic            pop;
   logic            flush;
   logic            push_ok;
   logic            err_set;
   logic [31:0]     correct_pc;

   assign full_o  = full;
   assign count_o = cnt;

   // Head compare, accept/pop/flush decisions for this cycle
   always_comb begin
      hd_pc      = pc_mem[head];
      hd_taken   = taken_mem[head];
      hd_target  = target_mem[head];
      empty      = (cnt == '0);
      full       = (cnt == FULL_CNT);
      pc_bad     = (hd_pc != res_pc_i);
      miss       = (hd_taken != res_taken_i) ||
                   (hd_taken && res_taken_i && (hd_target != res_target_i)) ||
                   pc_bad;
      correct_pc = res_taken_i ? res_target_i : (res_pc_i + 32'd4);
      do_res     = (state == RUN) && resolve_i && !empty;
      pop        = do_res && !miss;
      flush      = do_res && miss;
      // A pop in the same cycle frees a slot, so a push into a full queue is still taken.
      push_ok    = (state == RUN) && push_i && !flush && (!full || pop);
      err_set    = ((state == RUN) && resolve_i && empty) ||
                   ((state == RUN) && push_i && full && !pop && !flush) ||
                   (flush && pc_bad);
   end

   // Prediction record storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[tail]     <= push_pc_i;
         taken_mem[tail]  <= push_taken_i;
         target_mem[tail] <= push_target_i;
      end
   end

   // Control FSM, queue pointers and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= RUN;
         hold_cnt      <= '0;
         head          <= '0;
         tail          <= '0;
         cnt           <= '0;
         br_sig_o      <= 1'b0;
         miss_pred_o   <= 1'b0;
         redirect_o    <= 1'b0;
         redirect_pc_o <= '0;
         err_o         <= 1'b0;
      end else begin
         br_sig_o    <= do_res;
         miss_pred_o <= flush;
         redirect_o  <= flush;
         if (err_set)
            err_o <= 1'b1;
         case (state)
            RUN: begin
               if (flush) begin
                  redirect_pc_o <= correct_pc;
                  head          <= tail;
                  cnt           <= '0;
                  hold_cnt      <= HOLD_INIT;
                  state         <= HOLD;
               end else begin
                  if (pop)
                     head <= head + 1'b1;
                  if (push_ok)
                     tail <= tail + 1'b1;
                  if (push_ok && !pop)
                     cnt <= cnt + 1'b1;
                  else if (pop && !push_ok)
                     cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (hold_cnt <= 4'd1)
                  state <= RUN;
               else
                  hold_cnt <= hold_cnt - 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_br_resolver.sv
// Directed bench for br_resolver (DEPTH=4, FLUSH_CYC=2).
module tb_br_resolver;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        push_i = 1'b0;
   logic [31:0] push_pc_i = '0;
   logic        push_taken_i = 1'b0;
   logic [31:0] push_target_i = '0;
   logic        full_o;
   logic [2:0]  count_o;
   logic        resolve_i = 1'b0;
   logic [31:0] res_pc_i = '0;
   logic        res_taken_i = 1'b0;
   logic [31:0] res_target_i = '0;
   logic        br_sig_o;
   logic        miss_pred_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        err_o;

   int checks = 0;
   int failures = 0;

   br_resolver #(.DEPTH(4), .FLUSH_CYC(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .push_i(push_i), .push_pc_i(push_pc_i), .push_taken_i(push_taken_i),
      .push_target_i(push_target_i), .full_o(full_o), .count_o(count_o),
      .resolve_i(resolve_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
      .res_target_i(res_target_i), .br_sig_o(br_sig_o), .miss_pred_o(miss_pred_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic en, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      push_i = en; push_pc_i = pc; push_taken_i = tk; push_target_i = tg;
   endtask

   task automatic set_res(input logic en, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      resolve_i = en; res_pc_i = pc; res_taken_i = tk; res_target_i = tg;
   endtask

   task automatic check_pulses(input string tag, input logic br, input logic mp, input logic rd);
      check({tag, "_br"}, 32'(br_sig_o), 32'(br));
      check({tag, "_miss"}, 32'(miss_pred_o), 32'(mp));
      check({tag, "_redir"}, 32'(redirect_o), 32'(rd));
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check_pulses("rst", 1'b0, 1'b0, 1'b0);
      check("rst_rpc", redirect_pc_o, 32'h0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_cnt", 32'(count_o), 32'd0);
      check("rst_full", 32'(full_o), 32'd0);
      reset_n = 1'b1;
      tick();

      // Correct prediction
      set_push(1'b1, 32'h100, 1'b1, 32'h140); tick();
      check("t1_cnt1", 32'(count_o), 32'd1);
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 32'h100, 1'b1, 32'h140); tick();
      check_pulses("t1", 1'b1, 1'b0, 1'b0);
      check("t1_cnt0", 32'(count_o), 32'd0);
      set_res(1'b0, '0, 1'b0, '0); tick();
      check("t1_br_once", 32'(br_sig_o), 32'd0);

      // Direction mispredict, then HOLD window
      set_push(1'b1, 32'h200, 1'b1, 32'h180); tick();
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 32'h200, 1'b0, 32'h0); tick();
      check_pulses("t2", 1'b1, 1'b1, 1'b1);
      check("t2_rpc", redirect_pc_o, 32'h204);
      check("t2_cnt", 32'(count_o), 32'd0);
      check("t2_err", 32'(err_o), 32'd0);
      set_res(1'b0, '0, 1'b0, '0);
      set_push(1'b1, 32'h300, 1'b0, 32'h0); tick();
      check("t2_hold1_cnt", 32'(count_o), 32'd0);
      check("t2_redir_once", 32'(redirect_o), 32'd0);
      tick();
      check("t2_hold2_cnt", 32'(count_o), 32'd0);
      check("t2_rpc_held", redirect_pc_o, 32'h204);
      tick();
      check("t2_run_cnt", 32'(count_o), 32'd1);
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 32'h300, 1'b0, 32'hDEAD); tick();
      check_pulses("t2_drain", 1'b1, 1'b0, 1'b0);
      check("t2_drain_cnt", 32'(count_o), 32'd0);
      set_res(1'b0, '0, 1'b0, '0);

      // Fill, overflow, push+pop at full across wrap
      for (int i = 0; i < 4; i++) begin
         set_push(1'b1, 32'h400 + 32'(16*i), i[0], 32'h800 + 32'(16*i));
         tick();
      end
      check("t3_full", 32'(full_o), 32'd1);
      check("t3_cnt4", 32'(count_o), 32'd4);
      check("t3_err0", 32'(err_o), 32'd0);
      set_push(1'b1, 32'h999, 1'b1, 32'h999); tick();
      check("t3_ovf_err", 32'(err_o), 32'd1);
      check("t3_ovf_cnt", 32'(count_o), 32'd4);
      set_push(1'b1, 32'h440, 1'b1, 32'h900);
      set_res(1'b1, 32'h400, 1'b0, 32'h0); tick();
      check_pulses("t3_pp", 1'b1, 1'b0, 1'b0);
      check("t3_pp_cnt", 32'(count_o), 32'd4);
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 32'h410, 1'b1, 32'h810); tick();
      check_pulses("t3_r1", 1'b1, 1'b0, 1'b0);
      set_res(1'b1, 32'h420, 1'b0, 32'h0); tick();
      check_pulses("t3_r2", 1'b1, 1'b0, 1'b0);
      set_res(1'b1, 32'h430, 1'b1, 32'h830); tick();
      check_pulses("t3_r3", 1'b1, 1'b0, 1'b0);
      set_res(1'b1, 32'h440, 1'b1, 32'h900); tick();
      check_pulses("t3_r4", 1'b1, 1'b0, 1'b0);
      check("t3_end_cnt", 32'(count_o), 32'd0);
      set_res(1'b0, '0, 1'b0, '0);

      // Reset clears sticky error
      reset_n = 1'b0; tick();
      check("t4_err_clr", 32'(err_o), 32'd0);
      reset_n = 1'b1;

      // Resolve on empty queue
      set_res(1'b1, 32'h123, 1'b0, 32'h0); tick();
      check("t4_empty_err", 32'(err_o), 32'd1);
      check("t4_empty_br", 32'(br_sig_o), 32'd0);
      set_res(1'b0, '0, 1'b0, '0); tick();

      // PC+4 wrap on mispredict
      set_push(1'b1, 32'hFFFFFFFC, 1'b1, 32'h10); tick();
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 32'hFFFFFFFC, 1'b0, 32'h0); tick();
      check_pulses("t5", 1'b1, 1'b1, 1'b1);
      check("t5_rpc", redirect_pc_o, 32'h0);
      set_res(1'b0, '0, 1'b0, '0);

      // Reset in HOLD, then immediately back in RUN
      reset_n = 1'b0; tick();
      check_pulses("t6_rst", 1'b0, 1'b0, 1'b0);
      check("t6_err", 32'(err_o), 32'd0);
      check("t6_cnt", 32'(count_o), 32'd0);
      reset_n = 1'b1;
      set_push(1'b1, 32'h600, 1'b0, 32'h0); tick();
      check("t6_run_cnt", 32'(count_o), 32'd1);
      set_push(1'b1, 32'h610, 1'b0, 32'h0); tick();
      set_push(1'b1, 32'h620, 1'b0, 32'h0); tick();
      check("t6_cnt3", 32'(count_o), 32'd3);
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 32'h600, 1'b0, 32'h0);
      reset_n = 1'b0; tick();
      check("t6_rst2_cnt", 32'(count_o), 32'd0);
      check("t6_rst2_br", 32'(br_sig_o), 32'd0);
      check("t6_rst2_full", 32'(full_o), 32'd0);
      set_res(1'b0, '0, 1'b0, '0);
      reset_n = 1'b1; tick();
      check("t6_no_pend", 32'(br_sig_o), 32'd0);

      // PC-mismatch mispredict sets error
      set_push(1'b1, 32'h500, 1'b0, 32'h0); tick();
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 32'h504, 1'b0, 32'h0); tick();
      check_pulses("t7", 1'b1, 1'b1, 1'b1);
      check("t7_err", 32'(err_o), 32'd1);
      check("t7_rpc", redirect_pc_o, 32'h508);
      set_res(1'b0, '0, 1'b0, '0);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
